// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//
// This is the instruction-fetch stage of the pipelined RISC-V core. It owns
// the fetch PC and sends one instruction-memory request at a time over a
// valid/ready interface. It also fills the IF/ID pipeline register that
// decode reads. The stage follows the hazard unit (stallF/stallD/flushD) and
// the execute-stage redirect (PCsrcE/PCtargetE).
//
// The instruction memory may have variable latency. Only one request is
// ever outstanding. Each response arrives in order and is a single-cycle
// pulse that cannot be back-pressured. When decode is stalled, a one-entry
// skid buffer holds the arriving response. No new request is issued while
// that buffer is occupied, so it can never overflow.
//
// Ports
//   clk, rst_n                    rising-edge clock, async active-low reset
//   stallF, stallD, flushD        hazard-unit controls
//   PCsrcE, PCtargetE             taken branch/jump redirect from execute
//   imem_req_valid/addr/ready     request channel (address is PCF)
//   imem_rsp_valid/data           response channel
//   instrD, PCD, PCplus4D, validD IF/ID register
//   PCF                           current fetch PC
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        PCsrcE,
  input  logic [31:0] PCtargetE,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic [31:0] PCplus4D,
  output logic        validD,
  output logic [31:0] PCF
);

  // IDLE: nothing outstanding
  // WAIT: one request outstanding, its response will be used
  // DROP: one request outstanding, its response belongs to a squashed path
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] pc_inflight_q, pc_inflight_d;

  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;

  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [31:0] pcplus4_d_q, pcplus4_d_d;
  logic        valid_d_q, valid_d_d;

  logic        rsp_kept;
  logic        ifid_open;
  logic        req_valid;
  logic        handshake;

  // --------------------------------------------------------------------------
  // Request issue and handshake
  // --------------------------------------------------------------------------
  always_comb begin
    // A response is kept only when it answers a live (non-squashed) request
    // and no redirect squashes it in the same cycle.
    rsp_kept  = (state_q == S_WAIT) && imem_rsp_valid && !PCsrcE;
    ifid_open = !flushD && !stallD;

    // A back-to-back issue from WAIT is allowed only when the returning
    // response goes straight into IF/ID. That keeps the skid buffer free and
    // guarantees that at most one request is outstanding. The rst_n term
    // keeps the request low for the whole time reset is asserted.
    req_valid = rst_n && !PCsrcE && !stallF && !buf_valid_q &&
                ((state_q == S_IDLE) ||
                 ((state_q == S_WAIT) && imem_rsp_valid && ifid_open));
    handshake = req_valid && imem_req_ready;
  end

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (PCsrcE) begin
          // With no response yet, the stale response must still be drained.
          state_d = imem_rsp_valid ? S_IDLE : S_DROP;
        end else if (imem_rsp_valid) begin
          state_d = handshake ? S_WAIT : S_IDLE;
        end
      end
      S_DROP: begin
        // The squashed response retires the outstanding request, even when
        // another redirect arrives in the same cycle.
        if (imem_rsp_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // PC and in-flight tag
  // --------------------------------------------------------------------------
  always_comb begin
    pcf_d         = pcf_q;
    pc_inflight_d = pc_inflight_q;
    if (PCsrcE) begin
      pcf_d = PCtargetE;
    end else if (handshake) begin
      pcf_d = pcf_q + 32'd4;
    end
    if (handshake) pc_inflight_d = pcf_q;
  end

  // --------------------------------------------------------------------------
  // Skid buffer and IF/ID register
  // --------------------------------------------------------------------------
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;

    instr_d_d   = instr_d_q;
    pc_d_d      = pc_d_q;
    pcplus4_d_d = pcplus4_d_q;
    valid_d_d   = valid_d_q;

    // IF/ID priority: flush, then stall (hold), then buffered instruction,
    // then the kept response, and otherwise a bubble.
    if (flushD) begin
      instr_d_d   = NOP_INSTR;
      pc_d_d      = '0;
      pcplus4_d_d = '0;
      valid_d_d   = 1'b0;
    end else if (!stallD) begin
      if (buf_valid_q) begin
        instr_d_d   = buf_instr_q;
        pc_d_d      = buf_pc_q;
        pcplus4_d_d = buf_pc_q + 32'd4;
        valid_d_d   = 1'b1;
      end else if (rsp_kept) begin
        instr_d_d   = imem_rsp_data;
        pc_d_d      = pc_inflight_q;
        pcplus4_d_d = pc_inflight_q + 32'd4;
        valid_d_d   = 1'b1;
      end else begin
        instr_d_d   = NOP_INSTR;
        pc_d_d      = '0;
        pcplus4_d_d = '0;
        valid_d_d   = 1'b0;
      end
    end

    // A kept response that IF/ID does not take this cycle goes into the
    // skid buffer. A redirect squashes whatever the buffer holds.
    if (PCsrcE) begin
      buf_valid_d = 1'b0;
    end else if (rsp_kept && !(ifid_open && !buf_valid_q)) begin
      buf_valid_d = 1'b1;
      buf_instr_d = imem_rsp_data;
      buf_pc_d    = pc_inflight_q;
    end else if (ifid_open && buf_valid_q) begin
      buf_valid_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pcf_q         <= RESET_PC;
      pc_inflight_q <= '0;
      buf_valid_q   <= 1'b0;
      buf_instr_q   <= '0;
      buf_pc_q      <= '0;
      instr_d_q     <= NOP_INSTR;
      pc_d_q        <= '0;
      pcplus4_d_q   <= '0;
      valid_d_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pcf_q         <= pcf_d;
      pc_inflight_q <= pc_inflight_d;
      buf_valid_q   <= buf_valid_d;
      buf_instr_q   <= buf_instr_d;
      buf_pc_q      <= buf_pc_d;
      instr_d_q     <= instr_d_d;
      pc_d_q        <= pc_d_d;
      pcplus4_d_q   <= pcplus4_d_d;
      valid_d_q     <= valid_d_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pcf_q;
  assign PCF            = pcf_q;
  assign instrD         = instr_d_q;
  assign PCD            = pc_d_q;
  assign PCplus4D       = pcplus4_d_q;
  assign validD         = valid_d_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RISC-V core: owns the PC register, issues requests to the instruction memory over a valid/ready interface, and loads the IF/ID pipeline register consumed by decode. It sits directly upstream of decode. It obeys the hazard unit's stallF/stallD/flushD outputs and the execute-stage redirect (PCsrcE/PCtargetE). It tolerates variable-latency instruction memory with at most one request outstanding and a one-entry skid buffer.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stallF  in  1  hazard unit: hold PC, issue no new request
- stallD  in  1  hazard unit: hold IF/ID register
- flushD  in  1  hazard unit: bubble IF/ID register
- PCsrcE  in  1  taken branch/jump in execute
- PCtargetE  in  32  redirect target
- imem_req_valid  out  1  request valid
- imem_req_addr  out  32  request address (PCF)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid (one per accepted request, in order, ≥1 cycle after acceptance)
- imem_rsp_data  in  32  instruction word
- instrD  out  32  IF/ID instruction
- PCD  out  32  IF/ID PC
- PCplus4D  out  32  IF/ID PC+4
- validD  out  1  IF/ID holds a real instruction
- PCF  out  32  current fetch PC

## Operation
- Registers: PCF, pc_inflight, FSM, skid buffer (buf_valid, buf_instr, buf_pc), IF/ID (instrD, PCD, PCplus4D, validD).
- FSM states: IDLE (nothing outstanding), WAIT (outstanding, response kept), DROP (outstanding, response discarded).
- Issue condition: imem_req_valid = !PCsrcE && !stallF && !buf_valid && (state==IDLE || (state==WAIT && imem_rsp_valid && !stallD && !flushD)). Handshake = imem_req_valid && imem_req_ready; then pc_inflight<=PCF, PCF<=PCF+4, next state WAIT.
- WAIT + imem_rsp_valid, no redirect: instruction tagged pc_inflight; goes to IF/ID if IF/ID loads this cycle, else into skid buffer. Next state WAIT if new handshake same cycle, else IDLE.
- PCsrcE=1 (any state): PCF<=PCtargetE; buf_valid<=0; no request issued this cycle; WAIT without response that cycle → DROP; WAIT with response that cycle → response discarded, → IDLE; DROP stays DROP.
- DROP + imem_rsp_valid: response discarded, → IDLE.
- IF/ID load, priority order: flushD → instrD=NOP_INSTR, validD=0, PCD/PCplus4D=0; else stallD → hold; else buffer valid → load buffer, buf_valid<=0; else kept response this cycle → load it; else bubble (as flush).
- PCplus4D = PCD source + 4, modulo 2^32; PCF increment wraps 32'hFFFF_FFFC→0.
- flushD and stallD both high: flush wins.

## Timing
- Reset (async assert, any state): PCF=RESET_PC, state IDLE, buf_valid=0, instrD=NOP_INSTR, validD=0, PCD=0, PCplus4D=0; imem_req_valid=0 while rst_n=0. Response arriving during or after reset for a pre-reset request is ignored (state IDLE).
- First request asserted the first cycle after rst_n deasserts.
- Zero-wait memory (ready=1, response next cycle): one instruction per cycle into IF/ID; first instruction valid in IF/ID 2 cycles after its request handshake.
- Redirect: target requested the cycle after PCsrcE (if IDLE), or after the stale response drains.
- imem_req_valid/addr held stable until handshake unless PCsrcE or stallF drops it.
- Never more than one request outstanding; skid buffer never overflows (no issue while buf_valid).

## Test plan
- Reset, RESET_PC=0x100, memory 1-cycle, no hazards → requests 0x100,0x104,0x108 on consecutive cycles; instrD/PCD follow 2 cycles later with validD=1.
- stallD=1 for 3 cycles while response 0x00500093 arrives → captured in buffer, no new request; after release IF/ID loads 0x00500093, PCD correct, no instruction lost or duplicated.
- 3-cycle memory latency, PCsrcE=1 target 0x200 mid-wait → stale response dropped, next request address 0x200, IF/ID bubble (NOP, validD=0) in between.
- flushD=1 and stallD=1 same cycle → instrD=0x00000013, validD=0.
- imem_req_ready=0 for 4 cycles → imem_req_addr stable, PCF unchanged; PCF=0xFFFF_FFFC fetched → PCF wraps to 0.
- rst_n asserted while in WAIT → all outputs at reset values immediately (asynchronous); late response ignored; fetch restarts at RESET_PC.
